conv_frame_stats: RTL and testbench

//   Downstream consumer of the CONV output stream. Collects each 15-sample

---
 rtl/conv_frame_stats.sv | 165 ++++++++++++++++
 tb/tb_conv_frame_stats.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_stats.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_stats
// Brief    : Per-frame peak/index/sum of the CONV output stream, queued for a
//            host behind a valid/ready handshake with sticky drop flag.
// Revision : 1.0 - initial release
// ============================================================================
module conv_frame_stats #(
  parameter int FRAME_LEN = 15,
  parameter int DW        = 8,
  parameter int IDX_W     = 4,
  parameter int SUM_W     = 12,
  parameter int QDEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DW-1:0]    Din,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [DW-1:0]    res_peak,
  output logic [IDX_W-1:0] res_idx,
  output logic [SUM_W-1:0] res_sum,
  output logic [7:0]       res_frame,
  output logic             frame_busy,
  output logic             ovf
);

  localparam int                PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [IDX_W-1:0]  c_last  = IDX_W'(FRAME_LEN - 1);
  localparam logic [PTR_W:0]    c_depth = (PTR_W + 1)'(QDEPTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_last;

  logic [IDX_W-1:0] r_count;
  logic [DW-1:0]    r_peak;
  logic [IDX_W-1:0] r_idx;
  logic [SUM_W-1:0] r_sum;
  logic [7:0]       r_frame_no;
  logic             r_ovf;

  logic [DW-1:0]    w_peak_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [SUM_W-1:0] w_sum_nxt;

  logic [DW-1:0]    r_q_peak  [QDEPTH];
  logic [IDX_W-1:0] r_q_idx   [QDEPTH];
  logic [SUM_W-1:0] r_q_sum   [QDEPTH];
  logic [7:0]       r_q_frame [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_q_cnt;

  logic             w_full;
  logic             w_pop;
  logic             w_push;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (in_valid && (r_count == c_last)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strict greater-than keeps the first occurrence of the maximum.
  always_comb begin
    w_peak_nxt = r_peak;
    w_idx_nxt  = r_idx;
    w_sum_nxt  = r_sum;
    if (r_state == S_IDLE) begin
      w_peak_nxt = Din;
      w_idx_nxt  = '0;
      w_sum_nxt  = SUM_W'(Din);
    end else begin
      if (Din > r_peak) begin
        w_peak_nxt = Din;
        w_idx_nxt  = r_count;
      end
      w_sum_nxt = r_sum + SUM_W'(Din);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_peak  <= '0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (in_valid) begin
      r_count <= w_last ? '0 : r_count + IDX_W'(1);
      r_peak  <= w_peak_nxt;
      r_idx   <= w_idx_nxt;
      r_sum   <= w_sum_nxt;
    end
  end

  assign w_full = (r_q_cnt == c_depth);
  assign w_pop  = res_valid && res_ready;
  // A pop on the commit edge frees the slot the new record needs.
  assign w_push = w_last && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_q_cnt    <= '0;
      r_frame_no <= '0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_peak[i]  <= '0;
        r_q_idx[i]   <= '0;
        r_q_sum[i]   <= '0;
        r_q_frame[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_q_peak[r_wr_ptr]  <= w_peak_nxt;
        r_q_idx[r_wr_ptr]   <= w_idx_nxt;
        r_q_sum[r_wr_ptr]   <= w_sum_nxt;
        r_q_frame[r_wr_ptr] <= r_frame_no;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + (PTR_W + 1)'(1);
        2'b01:   r_q_cnt <= r_q_cnt - (PTR_W + 1)'(1);
        default: r_q_cnt <= r_q_cnt;
      endcase
      if (w_last)            r_frame_no <= r_frame_no + 8'd1;
      if (w_last && !w_push) r_ovf      <= 1'b1;
    end
  end

  assign res_valid  = (r_q_cnt != '0);
  assign res_peak   = r_q_peak[r_rd_ptr];
  assign res_idx    = r_q_idx[r_rd_ptr];
  assign res_sum    = r_q_sum[r_rd_ptr];
  assign res_frame  = r_q_frame[r_rd_ptr];
  assign frame_busy = (r_state == S_ACCUM);
  assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_frame_stats
// Brief    : Directed and scoreboard bench for conv_frame_stats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_frame_stats;

  localparam int FL = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  Din;
  logic        res_ready;
  logic        res_valid;
  logic [7:0]  res_peak;
  logic [3:0]  res_idx;
  logic [11:0] res_sum;
  logic [7:0]  res_frame;
  logic        frame_busy;
  logic        ovf;

  conv_frame_stats dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .Din        (Din),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_peak   (res_peak),
    .res_idx    (res_idx),
    .res_sum    (res_sum),
    .res_frame  (res_frame),
    .frame_busy (frame_busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole-frame statistics computed from a sample list.
  typedef struct {
    int peak;
    int idx;
    int sum;
    int frame;
  } rec_t;

  int   m_samples[$];
  rec_t m_q[$];
  int   m_frame;
  bit   m_ovf;

  initial begin : model
    rec_t r;
    bit   pop;
    m_frame = 0;
    m_ovf   = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_samples.delete();
        m_q.delete();
        m_frame = 0;
        m_ovf   = 1'b0;
      end else begin
        pop = (m_q.size() != 0) && res_ready;
        if (pop) void'(m_q.pop_front());
        if (in_valid) begin
          m_samples.push_back(int'(Din));
          if (m_samples.size() == FL) begin
            r.peak = -1;
            r.idx  = 0;
            r.sum  = 0;
            foreach (m_samples[i]) begin
              if (m_samples[i] > r.peak) begin
                r.peak = m_samples[i];
                r.idx  = i;
              end
              r.sum += m_samples[i];
            end
            r.frame = m_frame;
            m_frame = (m_frame + 1) % 256;
            if (m_q.size() < 2) m_q.push_back(r);
            else                m_ovf = 1'b1;
            m_samples.delete();
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("res_valid", res_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("res_peak",  res_peak,  m_q[0].peak);
        chk("res_idx",   res_idx,   m_q[0].idx);
        chk("res_sum",   res_sum,   m_q[0].sum);
        chk("res_frame", res_frame, m_q[0].frame);
      end
      chk("frame_busy", frame_busy, m_samples.size() != 0);
      chk("ovf",        ovf,        m_ovf);
    end
  end

  logic [7:0] frm [FL];

  task automatic cyc(input bit v, input logic [7:0] d);
    in_valid = v;
    Din      = v ? d : 8'bx;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    reset = 1'b0;
  endtask

  // Sends frm[]; optional 3-cycle gaps after given sample numbers (1-based);
  // pop_last raises res_ready only on the final sample's edge.
  task automatic send_frame(input int gap_a, input int gap_b, input bit pop_last);
    for (int i = 0; i < FL; i++) begin
      if (pop_last && i == FL - 1) res_ready = 1'b1;
      cyc(1'b1, frm[i]);
      if (pop_last && i == FL - 1) res_ready = 1'b0;
      if (i + 1 == gap_a || i + 1 == gap_b) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 8'h00);
          chk("gap_busy", frame_busy, 1);
        end
      end
    end
    in_valid = 1'b0;
    Din      = 8'bx;
  endtask

  task automatic check_head(input string n, input int pk, input int ix, input int sm, input int fr);
    chk({n, "_valid"}, res_valid, 1);
    chk({n, "_peak"},  res_peak,  pk);
    chk({n, "_idx"},   res_idx,   ix);
    chk({n, "_sum"},   res_sum,   sm);
    chk({n, "_frame"}, res_frame, fr);
    chk({n, "_model_nonempty"}, m_q.size() != 0, 1);
    if (m_q.size() != 0) begin
      chk({n, "_model_peak"},  m_q[0].peak,  pk);
      chk({n, "_model_idx"},   m_q[0].idx,   ix);
      chk({n, "_model_sum"},   m_q[0].sum,   sm);
      chk({n, "_model_frame"}, m_q[0].frame, fr);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < FL; i++) frm[i] = (i < 8) ? 8'(i + 1) : 8'(15 - i);
  endtask

  task automatic load_const(input logic [7:0] v);
    for (int i = 0; i < FL; i++) frm[i] = v;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset     = 1'b1;
    in_valid  = 1'b0;
    Din       = 8'h00;
    res_ready = 1'b0;
    do_reset();

    chk("rst_valid", res_valid,  0);
    chk("rst_peak",  res_peak,   0);
    chk("rst_sum",   res_sum,    0);
    chk("rst_frame", res_frame,  0);
    chk("rst_busy",  frame_busy, 0);
    chk("rst_ovf",   ovf,        0);

    // 1: ramp frame, one-cycle latency
    res_ready = 1'b1;
    load_ramp();
    for (int i = 0; i < FL - 1; i++) cyc(1'b1, frm[i]);
    chk("t1_valid_before_last", res_valid, 0);
    cyc(1'b1, frm[FL-1]);
    in_valid = 1'b0;
    check_head("t1", 8'h08, 7, 12'h040, 0);
    cyc(1'b0, 8'h00);

    // 2: constant frames
    load_const(8'h05);
    send_frame(-1, -1, 1'b0);
    check_head("t2a", 8'h05, 0, 12'h04B, 1);
    load_const(8'hFF);
    send_frame(-1, -1, 1'b0);
    check_head("t2b", 8'hFF, 0, 12'hEF1, 2);
    cyc(1'b0, 8'h00);

    // 3: gaps inside the frame
    load_ramp();
    send_frame(4, 11, 1'b0);
    check_head("t3", 8'h08, 7, 12'h040, 3);
    cyc(1'b0, 8'h00);

    // 4: overflow with host stalled
    do_reset();
    res_ready = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(-1, -1, 1'b0);
    chk("t4_ovf", ovf, 1);
    check_head("t4_hold", 8'h08, 7, 12'h040, 0);
    res_ready = 1'b1;
    cyc(1'b0, 8'h00);
    check_head("t4_pop1", 8'h08, 7, 12'h040, 1);
    cyc(1'b0, 8'h00);
    chk("t4_empty", res_valid, 0);
    load_const(8'h05);
    send_frame(-1, -1, 1'b0);
    check_head("t4_next", 8'h05, 0, 12'h04B, 3);
    cyc(1'b0, 8'h00);

    // 5: full queue with pop on the commit edge
    do_reset();
    res_ready = 1'b0;
    load_const(8'h05);
    send_frame(-1, -1, 1'b0);
    load_ramp();
    send_frame(-1, -1, 1'b0);
    send_frame(-1, -1, 1'b1);
    chk("t5_ovf", ovf, 0);
    check_head("t5_head", 8'h08, 7, 12'h040, 1);
    res_ready = 1'b1;
    cyc(1'b0, 8'h00);
    check_head("t5_second", 8'h08, 7, 12'h040, 2);
    cyc(1'b0, 8'h00);
    chk("t5_empty", res_valid, 0);

    // 6: reset mid-frame
    do_reset();
    res_ready = 1'b1;
    load_ramp();
    for (int i = 0; i < 7; i++) cyc(1'b1, frm[i]);
    reset = 1'b1;
    cyc(1'b0, 8'h00);
    reset = 1'b0;
    chk("t6_busy_cleared", frame_busy, 0);
    for (int i = 0; i < FL; i++) frm[i] = 8'(10 + i);
    send_frame(-1, -1, 1'b0);
    check_head("t6", 8'h18, 14, 12'h0FF, 0);
    chk("t6_ovf", ovf, 0);
    cyc(1'b0, 8'h00);

    // Scoreboard: 5 frames (75 samples) with random gaps and host stalls
    do_reset();
    for (int n = 0; n < 5 * FL; n++) begin
      while ($urandom_range(0, 3) == 0) begin
        res_ready = 1'($urandom_range(0, 1));
        cyc(1'b0, 8'h00);
      end
      res_ready = 1'($urandom_range(0, 1));
      cyc(1'b1, 8'($urandom_range(0, 255)));
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00);
    chk("sb_drained", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
